compression: RTL

- Per-sample I/Q compressor for the TX-side fronthaul path. It is the inverse of the team's 8-bit-to-16-bit decompressor.
- Converts 16-bit two's-complement I and Q samples into the 8-bit sign/exponent/mantissa code.
- Round-to-nearest with saturation; 3-cycle fixed latency; sop/eop/valid sideband carried alongside.
- Framing monitor flags malformed packets and counts errors.

---
 rtl/compression_pkg.sv | 29 ++
 rtl/compression_lane.sv | 98 +++++++++
 rtl/compression.sv | 121 ++++++++++++
 3 files changed

// File: rtl/compression_pkg.sv
// Shared definitions for the I/Q compressor: code field layout, code limits
// and the framing state encoding.
package compression_pkg;

  localparam int SIGN_BIT = 7;
  localparam int EXP_MSB  = 6;
  localparam int EXP_LSB  = 4;
  localparam int MAN_W    = 4;

  localparam logic [3:0]  E_MAX   = 4'd7;
  localparam logic [3:0]  M_MAX   = 4'd15;
  localparam logic [15:0] MAG_MAX = 16'd31744;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_t;

  // Exponent from the leading one: below 256 the code is linear (e=0).
  function automatic logic [3:0] exp_of(input logic [15:0] mag);
    logic [3:0] e;
    e = 4'd0;
    for (int b = 8; b < 16; b++) begin
      if (mag[b]) e = 4'(b - 7);
    end
    return e;
  endfunction

endpackage

// File: rtl/compression_lane.sv
// Three-stage 16-bit to 8-bit sign/exponent/mantissa datapath for one sample.
// Each stage loads only when its beat is valid, so outputs hold between beats.
module compress_lane
  import compression_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en1,
  input  logic        en2,
  input  logic        en3,
  input  logic [15:0] x,
  output logic [7:0]  code,
  output logic        sat
);

  logic        s1;
  logic [15:0] mag1;

  logic        s2;
  logic [3:0]  e2;
  logic [3:0]  sh2;
  logic [16:0] r2;

  logic [3:0]  e_c;
  logic [3:0]  sh_c;
  logic [16:0] rnd_c;

  logic [5:0]  q_c;
  logic [5:0]  m_c;
  logic [3:0]  e3_c;
  logic        sat_c;
  logic [7:0]  code_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      mag1 <= '0;
    end else if (en1) begin
      s1   <= x[15];
      mag1 <= x[15] ? 16'(~x + 16'd1) : x;
    end
  end

  always_comb begin
    e_c   = exp_of(mag1);
    sh_c  = (e_c == 4'd0) ? 4'd4 : e_c + 4'd3;
    rnd_c = ROUND_EN ? (17'd1 << (sh_c - 4'd1)) : 17'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2  <= 1'b0;
      e2  <= '0;
      sh2 <= '0;
      r2  <= '0;
    end else if (en2) begin
      s2  <= s1;
      e2  <= e_c;
      sh2 <= sh_c;
      r2  <= {1'b0, mag1} + rnd_c;
    end
  end

  // Rounding can carry the mantissa to 16, which bumps the exponent and may
  // push it past the largest encodable value.
  always_comb begin
    q_c   = 6'(r2 >> sh2);
    m_c   = q_c - ((e2 != 4'd0) ? 6'd16 : 6'd0);
    e3_c  = e2;
    if (m_c == 6'd16) begin
      e3_c = e2 + 4'd1;
      m_c  = 6'd0;
    end
    sat_c = (e3_c > E_MAX);
    if (sat_c) begin
      e3_c = E_MAX;
      m_c  = {2'b00, M_MAX};
    end
    code_c                   = '0;
    code_c[SIGN_BIT]         = s2;
    code_c[EXP_MSB:EXP_LSB]  = e3_c[2:0];
    code_c[MAN_W-1:0]        = m_c[3:0];
    if (s2 && (e3_c == 4'd0) && (m_c == 6'd0)) code_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= '0;
      sat  <= 1'b0;
    end else if (en3) begin
      code <= code_c;
      sat  <= sat_c;
    end
  end

endmodule

// File: rtl/compression.sv
// I/Q compressor top: two compress_lane datapaths, a 3-deep sideband delay line,
// the packet framing monitor and saturating event counters.
module compression
  import compression_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [15:0]      data_in_i,
  input  logic [15:0]      data_in_q,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [7:0]       data_out_i,
  output logic [7:0]       data_out_q,
  output logic             out_sat,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sat_cnt
);

  logic [2:0] valid_d;
  logic [2:0] sop_d;
  logic [2:0] eop_d;
  logic [2:0] err_d;

  logic sat_i;
  logic sat_q;

  frame_state_t state;
  frame_state_t state_next;
  logic         err_now;

  compress_lane #(.ROUND_EN(ROUND_EN)) lane_i (
    .clk   (clk),
    .rst_n (rst_n),
    .en1   (in_valid),
    .en2   (valid_d[0]),
    .en3   (valid_d[1]),
    .x     (data_in_i),
    .code  (data_out_i),
    .sat   (sat_i)
  );

  compress_lane #(.ROUND_EN(ROUND_EN)) lane_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en1   (in_valid),
    .en2   (valid_d[0]),
    .en3   (valid_d[1]),
    .x     (data_in_q),
    .code  (data_out_q),
    .sat   (sat_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d <= '0;
      sop_d   <= '0;
      eop_d   <= '0;
      err_d   <= '0;
    end else begin
      valid_d <= {valid_d[1:0], in_valid};
      sop_d   <= {sop_d[1:0], in_valid & in_sop};
      eop_d   <= {eop_d[1:0], in_valid & in_eop};
      err_d   <= {err_d[1:0], err_now};
    end
  end

  assign out_valid = valid_d[2];
  assign out_sop   = sop_d[2];
  assign out_eop   = eop_d[2];
  assign frame_err = err_d[2];
  assign out_sat   = sat_i | sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A nested sop restarts the packet, so it closes only if eop rides with it.
  always_comb begin
    state_next = state;
    if (in_valid) begin
      case (state)
        IDLE:    if (in_sop && !in_eop) state_next = IN_PKT;
        IN_PKT:  if (in_eop)            state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    err_now = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE:    err_now = !in_sop;
        IN_PKT:  err_now = in_sop;
        default: err_now = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      sat_cnt <= '0;
    end else begin
      if (frame_err && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_W'(1);
      if (out_valid && out_sat && (sat_cnt != '1))
        sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule
